// File: rtl/axi_lsu_route_ctrl.sv
// Address-decoded AXI4 router control for the LSU master: local memory (target 0)
// and peripheral bridge (target 1). Steers valid/ready and payload mux selects per channel.
//
// Write FSM states:
//   state   | meaning
//   WR_IDLE | AW routed to decoded slave, waiting for AW handshake
//   WR_DATA | W routed to w_sel slave until the wlast beat is accepted
//   WR_RESP | B routed to b_sel slave until the response is accepted
module axi_lsu_route_ctrl #(
  parameter int          MAX_RD_OUTST = 4,
  parameter logic [31:0] BRIDGE_LO    = 32'h2000_0000,
  parameter logic [31:0] BRIDGE_HI    = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_l,
  // AR
  input  logic        m_arvalid,
  input  logic [31:0] m_araddr,
  output logic        m_arready,
  output logic        mem_arvalid,
  output logic        br_arvalid,
  input  logic        mem_arready,
  input  logic        br_arready,
  output logic        ar_sel,
  // R
  input  logic        mem_rvalid,
  input  logic        br_rvalid,
  input  logic        mem_rlast,
  input  logic        br_rlast,
  output logic        m_rvalid,
  input  logic        m_rready,
  output logic        mem_rready,
  output logic        br_rready,
  output logic        r_sel,
  // AW
  input  logic        m_awvalid,
  input  logic [31:0] m_awaddr,
  output logic        m_awready,
  output logic        mem_awvalid,
  output logic        br_awvalid,
  input  logic        mem_awready,
  input  logic        br_awready,
  output logic        aw_sel,
  // W
  input  logic        m_wvalid,
  input  logic        m_wlast,
  output logic        m_wready,
  output logic        mem_wvalid,
  output logic        br_wvalid,
  input  logic        mem_wready,
  input  logic        br_wready,
  output logic        w_sel,
  // B
  input  logic        mem_bvalid,
  input  logic        br_bvalid,
  output logic        m_bvalid,
  input  logic        m_bready,
  output logic        mem_bready,
  output logic        br_bready,
  output logic        b_sel,
  // status
  output logic [3:0]  rd_outst,
  output logic        wr_busy
);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  wr_state_t wr_state, wr_state_nxt;

  logic ar_dec, aw_dec;
  logic ar_ok, ar_hs;
  logic rd_active, r_last, r_done;
  logic aw_hs;
  logic rd_tgt;

  assign ar_dec = (m_araddr >= BRIDGE_LO) && (m_araddr <= BRIDGE_HI);
  assign aw_dec = (m_awaddr >= BRIDGE_LO) && (m_awaddr <= BRIDGE_HI);
  assign ar_sel = ar_dec;
  assign aw_sel = aw_dec;

  // Reads to a new target wait until every read to the old one has retired.
  assign ar_ok = (rd_outst == 4'd0) ||
                 ((ar_dec == rd_tgt) && (rd_outst < 4'(MAX_RD_OUTST)));

  assign mem_arvalid = ar_ok & m_arvalid & ~ar_dec;
  assign br_arvalid  = ar_ok & m_arvalid & ar_dec;
  assign m_arready   = ar_ok & (ar_dec ? br_arready : mem_arready);
  assign ar_hs       = m_arvalid & m_arready;

  assign r_sel      = rd_tgt;
  assign rd_active  = (rd_outst != 4'd0);
  assign m_rvalid   = rd_active & (rd_tgt ? br_rvalid : mem_rvalid);
  assign mem_rready = rd_active & ~rd_tgt & m_rready;
  assign br_rready  = rd_active & rd_tgt & m_rready;
  assign r_last     = rd_tgt ? br_rlast : mem_rlast;
  assign r_done     = m_rvalid & m_rready & r_last;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_outst <= 4'd0;
      rd_tgt   <= 1'b0;
    end else begin
      if (ar_hs) rd_tgt <= ar_dec;
      case ({ar_hs, r_done})
        2'b10:   rd_outst <= rd_outst + 4'd1;
        2'b01:   rd_outst <= rd_outst - 4'd1;
        default: rd_outst <= rd_outst;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    m_awready    = 1'b0;
    mem_awvalid  = 1'b0;
    br_awvalid   = 1'b0;
    m_wready     = 1'b0;
    mem_wvalid   = 1'b0;
    br_wvalid    = 1'b0;
    m_bvalid     = 1'b0;
    mem_bready   = 1'b0;
    br_bready    = 1'b0;
    aw_hs        = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        mem_awvalid = m_awvalid & ~aw_dec;
        br_awvalid  = m_awvalid & aw_dec;
        m_awready   = aw_dec ? br_awready : mem_awready;
        aw_hs       = m_awvalid & m_awready;
        if (aw_hs) wr_state_nxt = WR_DATA;
      end
      WR_DATA: begin
        mem_wvalid = m_wvalid & ~w_sel;
        br_wvalid  = m_wvalid & w_sel;
        m_wready   = w_sel ? br_wready : mem_wready;
        if (m_wvalid && m_wready && m_wlast) wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_bvalid   = b_sel ? br_bvalid : mem_bvalid;
        mem_bready = m_bready & ~b_sel;
        br_bready  = m_bready & b_sel;
        if (m_bvalid && m_bready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      w_sel <= 1'b0;
      b_sel <= 1'b0;
    end else if (aw_hs) begin
      w_sel <= aw_dec;
      b_sel <= aw_dec;
    end
  end

  assign wr_busy = (wr_state != WR_IDLE);

endmodule
